adder_measure_sequencer: RTL
============================

Name: adder_measure_sequencer

Overview:
- Drives one timing run of the instrumented adder and collects its results.
- Latches operands and a trial count, then runs N back-to-back trials: present operands, pulse start, wait for done, capture sum and ring-oscillator count.
- Reports min/max propagation count, mismatch count and timeout status to the logic-analyzer readback.
- Sits between the LA/io control registers and the instrumented adder.

Parameters:
WIDTH, 32, operand/sum width
CNT_W, 16, width of the ring-oscillator count returned by the adder
TIMEOUT, 1023, max wb_clk_i cycles to wait for dut_done per trial (must fit 10 bits)

Ports:
wb_clk_i  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
go  input  1  single-cycle request to start a run; ignored unless idle or done
cfg_a  input  WIDTH  operand A, sampled on accepted go
cfg_b  input  WIDTH  operand B, sampled on accepted go
cfg_trials  input  8  number of trials; 0 is treated as 1
dut_a  output  WIDTH  operand A to adder
dut_b  output  WIDTH  operand B to adder
dut_start  output  1  one-cycle start pulse to adder
dut_done  input  1  adder measurement complete; level, sampled in WAIT only
dut_sum  input  WIDTH  adder sum
dut_count  input  CNT_W  ring-oscillator count for the trial
busy  output  1  high from accepted go until DONE is entered
result_valid  output  1  high in DONE until the next accepted go
min_count  output  CNT_W  smallest dut_count in the run
max_count  output  CNT_W  largest dut_count in the run
err_count  output  8  trials whose sum mismatched, plus timeouts; saturates at 255
timeout  output  1  sticky: the run aborted on timeout

Behaviour:
- Reset (async, any state): FSM=IDLE.
  - dut_a, dut_b, dut_start, busy, result_valid, max_count, err_count, timeout = 0.
  - min_count = all ones.
  - Internal trial and timeout counters = 0.
- FSM states: IDLE, LOAD, START, WAIT, CHECK, DONE.
- IDLE/DONE, go=1:
  - Latch cfg_a/cfg_b into dut_a/dut_b; latch cfg_trials (0→1).
  - Clear trial counter, err_count, timeout and result_valid; min_count=all ones, max_count=0.
  - busy=1; go to LOAD.
- LOAD: one settle cycle with operands stable → START.
- START: dut_start=1 for exactly this cycle → WAIT; clear timeout counter.
- WAIT, dut_done=1: register dut_sum and dut_count → CHECK.
- WAIT, otherwise: increment timeout counter.
  - When the counter reaches TIMEOUT with no done: timeout=1, err_count+1 (saturating) → DONE.
  - Remaining trials are skipped; min/max keep their values so far.
- CHECK:
  - If sum ≠ (dut_a+dut_b) mod 2^WIDTH, err_count+1 (saturating).
  - min_count=min(min,count); max_count=max(max,count); trial counter+1.
  - Counter equals trials → DONE; else → LOAD.
- DONE: busy=0, result_valid=1; outputs hold until the next accepted go.
- dut_a/dut_b change only on accepted go or reset; they are stable across all trials.
- go while busy is ignored; it does not queue.
- dut_done outside WAIT is ignored. A done on the same cycle as the timeout threshold counts as done (done has priority).
- Trial latency without timeout: trial 1 has go→start = 2 cycles. Each trial takes LOAD+START+WAIT(k)+CHECK = k+3 cycles, where k ≥ 1 is the number of WAIT cycles up to and including the done cycle.
- Timeout count compare is unsigned and uses a counter at least 10 bits wide.

Test Plan:
- Reset then idle: after rst_n release, min_count=0xFFFF, max_count=0, busy=0, result_valid=0, dut_start never asserted.
- Single trial: a=5, b=7, trials=1, model returns sum=12, count=40 after 3 cycles → exactly one dut_start pulse; result_valid=1; min=max=40; err_count=0.
- Multi-trial min/max with wrap:
  - Setup: a=0xFFFFFFFF, b=1, trials=3; counts 50, 30, 70; sums 0, 0, 1.
  - Required: 3 start pulses, min=30, max=70, err_count=1; dut_a/dut_b stable throughout.
- Timeout: trials=4, model never asserts done → timeout=1, err_count=1, result_valid=1 exactly TIMEOUT cycles after WAIT entry; only one start pulse.
- go while busy plus trials=0:
  - trials=0 runs exactly one trial.
  - A second go asserted mid-run is ignored: operands unchanged, no extra trial.
  - A go in DONE restarts the run with cleared stats.
- Reset mid-WAIT: deassert rst_n during a trial → all outputs return to reset values immediately and asynchronously; a late dut_done after reset release has no effect.

Source files
------------

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: runs N timed trials on the instrumented adder and collects min/max count and error stats
module adder_measure_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [7:0]       cfg_trials,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_start,
  input  logic             dut_done,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic [CNT_W-1:0] dut_count,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
  output logic [7:0]       err_count,
  output logic             timeout
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] trials, tcnt, err_inc;
  logic [9:0] to_cnt;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic accept, to_hit, last, bad;
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    accept = go && (state == IDLE || state == DONE);
    to_hit = state == WAIT && !dut_done && to_cnt == 10'(TIMEOUT - 1);
    last = {1'b0, tcnt} + 9'd1 == {1'b0, trials};
    bad = sum_r != WIDTH'(dut_a + dut_b);
    err_inc = err_count + {7'd0, err_count != 8'hff};
    dut_start = state == START;
    busy = state == LOAD || state == START || state == WAIT || state == CHECK;
    result_valid = state == DONE;
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? LOAD : state;
      LOAD: state_nx = START;
      START: state_nx = WAIT;
      WAIT: state_nx = dut_done ? CHECK : to_hit ? DONE : WAIT;
      CHECK: state_nx = last ? DONE : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      dut_a <= '0;
      dut_b <= '0;
      trials <= '0;
      tcnt <= '0;
      to_cnt <= '0;
      sum_r <= '0;
      cnt_r <= '0;
      min_count <= '1;
      max_count <= '0;
      err_count <= '0;
      timeout <= 1'b0;
    end else begin
      if (accept) begin
        dut_a <= cfg_a;
        dut_b <= cfg_b;
        trials <= cfg_trials == 8'd0 ? 8'd1 : cfg_trials;
        tcnt <= '0;
        err_count <= '0;
        timeout <= 1'b0;
        min_count <= '1;
        max_count <= '0;
      end
      if (state == START) to_cnt <= '0;
      if (state == WAIT && dut_done) begin
        sum_r <= dut_sum;
        cnt_r <= dut_count;
      end
      if (state == WAIT && !dut_done) to_cnt <= to_cnt + 10'd1;
      if (to_hit) begin
        timeout <= 1'b1;
        err_count <= err_inc;
      end
      if (state == CHECK) begin
        err_count <= bad ? err_inc : err_count;
        min_count <= cnt_r < min_count ? cnt_r : min_count;
        max_count <= cnt_r > max_count ? cnt_r : max_count;
        tcnt <= tcnt + 8'd1;
      end
    end
endmodule
